// File: rtl/quadtree_switch_allocator_pkg.sv
// Shared definitions for the quadtree NoC switch allocator.
// Provides port-count/credit constants and the round-robin scan-order helper.
package quadtree_switch_allocator_pkg;

  localparam int unsigned NUM_PORT        = 5;
  localparam int unsigned PORT_UP         = 4;
  localparam int unsigned SA_CREDIT_DEPTH = 4;
  localparam int unsigned CREDIT_WIDTH    = 3;
  localparam int unsigned PTR_W           = 3;
  localparam int unsigned SEL_W           = NUM_PORT * NUM_PORT;
  localparam int unsigned STALL_W         = 16;

  // Port visited at step k of a scan starting at ptr (ptr, ptr+1, ... mod NUM_PORT).
  function automatic logic [PTR_W-1:0] scan_port(input logic [PTR_W-1:0] ptr,
                                                  input int unsigned     k);
    int unsigned s;
    s = 32'(ptr) + k;
    if (s >= NUM_PORT) s = s - NUM_PORT;
    return PTR_W'(s);
  endfunction

endpackage

// File: rtl/quadtree_switch_allocator_sa_credit_counter.sv
// Per-output credit counter (sa_credit_counter) for the switch allocator.
// Ports:
//   clk, rst        clock, async active-low reset (credit resets to DEPTH)
//   i_dec           output claimed this cycle (consumes one slot)
//   i_inc           downstream returned one slot
//   o_avail_c       combinational: at least one credit held
//   o_sat_err_c     combinational: return arrived while already full
module quadtree_switch_allocator_sa_credit_counter
  import quadtree_switch_allocator_pkg::*;
#(
  parameter int unsigned DEPTH = SA_CREDIT_DEPTH,
  parameter int unsigned WIDTH = CREDIT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic i_dec,
  input  logic i_inc,
  output logic o_avail_c,
  output logic o_sat_err_c
);

  logic [WIDTH-1:0] r_credit;
  logic             w_full;

  assign w_full      = (r_credit == WIDTH'(DEPTH));
  assign o_avail_c   = (r_credit != '0);
  assign o_sat_err_c = i_inc && !i_dec && w_full;

  // Simultaneous inc/dec cancel; a return at full credit saturates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_credit <= WIDTH'(DEPTH);
    end else if (i_inc && !i_dec) begin
      if (!w_full) r_credit <= r_credit + WIDTH'(1);
    end else if (i_dec && !i_inc) begin
      r_credit <= r_credit - WIDTH'(1);
    end
  end

endmodule

// File: rtl/quadtree_switch_allocator.sv
// Quadtree NoC switch allocator: atomic (multicast-safe) round-robin grant of
// whole requests against per-output credits, with a registered crossbar select.
// Ports:
//   clk, rst          clock, async active-low reset
//   in_req            per-input request
//   in_route_port     per-input output vector, slice [i*5 +: 5]
//   in_grant          combinational grant per input
//   out_credit_inc    per-output credit return pulse
//   st_valid          registered: output carries a flit next cycle
//   st_sel            registered: one-hot input select per output, slice [o*5 +: 5]
//   alloc_err         sticky error (zero route vector or credit overflow)
// Optional (QUADTREE_SA_STATS_EN): stats_clr in, stall_cnt out (16 bits per input).
module quadtree_switch_allocator
  import quadtree_switch_allocator_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_PORT-1:0]   in_req,
  input  logic [SEL_W-1:0]      in_route_port,
  output logic [NUM_PORT-1:0]   in_grant,
  input  logic [NUM_PORT-1:0]   out_credit_inc,
`ifdef QUADTREE_SA_STATS_EN
  input  logic                  stats_clr,
  output logic [NUM_PORT*STALL_W-1:0] stall_cnt,
`endif
  output logic [NUM_PORT-1:0]   st_valid,
  output logic [SEL_W-1:0]      st_sel,
  output logic                  alloc_err
);

  logic [PTR_W-1:0]    r_rr_ptr;
  logic [NUM_PORT-1:0] r_st_valid;
  logic [SEL_W-1:0]    r_st_sel;
  logic                r_alloc_err;

  logic [NUM_PORT-1:0] w_avail;
  logic [NUM_PORT-1:0] w_sat_err;
  logic [NUM_PORT-1:0] w_grant;
  logic [NUM_PORT-1:0] w_claim;
  logic [SEL_W-1:0]    w_sel_nxt;
  logic                w_zero_err;
  logic                w_any;
  logic [PTR_W-1:0]    w_last;
  logic [PTR_W-1:0]    w_idx;
  logic [NUM_PORT-1:0] w_vec;

  // One credit counter per output.
  for (genvar o = 0; o < NUM_PORT; o++) begin : g_credit
    quadtree_switch_allocator_sa_credit_counter #(
      .DEPTH (SA_CREDIT_DEPTH),
      .WIDTH (CREDIT_WIDTH)
    ) u_credit (
      .clk         (clk),
      .rst         (rst),
      .i_dec       (w_claim[o]),
      .i_inc       (out_credit_inc[o]),
      .o_avail_c   (w_avail[o]),
      .o_sat_err_c (w_sat_err[o])
    );
  end

  // Round-robin scan; a request is granted only if all of its outputs are free.
  always_comb begin
    w_grant    = '0;
    w_claim    = '0;
    w_sel_nxt  = '0;
    w_zero_err = 1'b0;
    w_any      = 1'b0;
    w_last     = r_rr_ptr;
    w_idx      = '0;
    w_vec      = '0;
    for (int unsigned k = 0; k < NUM_PORT; k++) begin
      w_idx = scan_port(r_rr_ptr, k);
      w_vec = in_route_port[w_idx*NUM_PORT +: NUM_PORT];
      if (in_req[w_idx] && ((w_vec & ~w_avail) == '0) && ((w_vec & w_claim) == '0)) begin
        w_grant[w_idx] = 1'b1;
        w_claim        = w_claim | w_vec;
        w_any          = 1'b1;
        w_last         = w_idx;
        // An empty vector is drained so it cannot wedge the input.
        if (w_vec == '0) w_zero_err = 1'b1;
        for (int unsigned o = 0; o < NUM_PORT; o++) begin
          if (w_vec[o]) w_sel_nxt[o*NUM_PORT +: NUM_PORT] = NUM_PORT'(1) << w_idx;
        end
      end
    end
  end

  // Pointer, switch-traversal register and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr    <= '0;
      r_st_valid  <= '0;
      r_st_sel    <= '0;
      r_alloc_err <= 1'b0;
    end else begin
      if (w_any) r_rr_ptr <= scan_port(w_last, 1);
      r_st_valid  <= w_claim;
      r_st_sel    <= w_sel_nxt;
      r_alloc_err <= r_alloc_err | w_zero_err | (|w_sat_err);
    end
  end

`ifdef QUADTREE_SA_STATS_EN
  logic [NUM_PORT*STALL_W-1:0] r_stall_cnt;

  // Saturating per-input stall counters; clear wins over increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_PORT; i++) begin
        if (stats_clr) begin
          r_stall_cnt[i*STALL_W +: STALL_W] <= '0;
        end else if (in_req[i] && !w_grant[i] &&
                     (r_stall_cnt[i*STALL_W +: STALL_W] != 16'hFFFF)) begin
          r_stall_cnt[i*STALL_W +: STALL_W] <= r_stall_cnt[i*STALL_W +: STALL_W] + 16'd1;
        end
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

  assign in_grant  = w_grant;
  assign st_valid  = r_st_valid;
  assign st_sel    = r_st_sel;
  assign alloc_err = r_alloc_err;

endmodule

// File: tb/tb_quadtree_switch_allocator.sv
// Self-checking bench for quadtree_switch_allocator: a behavioural model predicts
// grants and the registered switch-traversal outputs, queued on drive and
// compared one cycle later.
module tb_quadtree_switch_allocator;
  import quadtree_switch_allocator_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic [NUM_PORT-1:0] in_req;
  logic [SEL_W-1:0]    in_route_port;
  logic [NUM_PORT-1:0] in_grant;
  logic [NUM_PORT-1:0] out_credit_inc;
  logic [NUM_PORT-1:0] st_valid;
  logic [SEL_W-1:0]    st_sel;
  logic                alloc_err;
`ifdef QUADTREE_SA_STATS_EN
  logic                stats_clr;
  logic [NUM_PORT*STALL_W-1:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  quadtree_switch_allocator dut (
    .clk            (clk),
    .rst            (rst),
    .in_req         (in_req),
    .in_route_port  (in_route_port),
    .in_grant       (in_grant),
    .out_credit_inc (out_credit_inc),
`ifdef QUADTREE_SA_STATS_EN
    .stats_clr      (stats_clr),
    .stall_cnt      (stall_cnt),
`endif
    .st_valid       (st_valid),
    .st_sel         (st_sel),
    .alloc_err      (alloc_err)
  );

  typedef struct {
    logic [NUM_PORT-1:0] valid;
    logic [SEL_W-1:0]    sel;
    logic                err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_cred[NUM_PORT];
  int   m_rr;
  logic m_err;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [SEL_W-1:0] rt(input int i, input logic [NUM_PORT-1:0] v);
    logic [SEL_W-1:0] r;
    r = '0;
    r[i*NUM_PORT +: NUM_PORT] = v;
    return r;
  endfunction

  task automatic model_reset();
    for (int o = 0; o < NUM_PORT; o++) m_cred[o] = SA_CREDIT_DEPTH;
    m_rr  = 0;
    m_err = 1'b0;
  endtask

  // Reference allocation from current model state.
  task automatic model_alloc(input logic [NUM_PORT-1:0] req, input logic [SEL_W-1:0] route,
                             output logic [NUM_PORT-1:0] gnt, output logic [NUM_PORT-1:0] claim,
                             output logic [SEL_W-1:0] sel, output logic zerr,
                             output int last, output logic any);
    logic [NUM_PORT-1:0] v;
    logic ok;
    int   i;
    gnt = '0; claim = '0; sel = '0; zerr = 1'b0; last = m_rr; any = 1'b0;
    for (int k = 0; k < NUM_PORT; k++) begin
      i  = (m_rr + k) % NUM_PORT;
      v  = route[i*NUM_PORT +: NUM_PORT];
      ok = req[i];
      for (int o = 0; o < NUM_PORT; o++)
        if (v[o] && (m_cred[o] == 0 || claim[o])) ok = 1'b0;
      if (ok) begin
        gnt[i] = 1'b1;
        claim  = claim | v;
        any    = 1'b1;
        last   = i;
        if (v == '0) zerr = 1'b1;
        for (int o = 0; o < NUM_PORT; o++)
          if (v[o]) sel[o*NUM_PORT +: NUM_PORT] = NUM_PORT'(1) << i;
      end
    end
  endtask

  // One allocation cycle: drive, check grant, queue expectation, compare after edge.
  task automatic step(input logic [NUM_PORT-1:0] req, input logic [SEL_W-1:0] route,
                      input logic [NUM_PORT-1:0] inc, output logic [NUM_PORT-1:0] gnt_obs);
    logic [NUM_PORT-1:0] gnt, claim;
    logic [SEL_W-1:0]    sel;
    logic                zerr, any;
    int                  last;
    exp_t                e;
    @(negedge clk);
    in_req = req; in_route_port = route; out_credit_inc = inc;
    #1;
    model_alloc(req, route, gnt, claim, sel, zerr, last, any);
    check_eq("in_grant", 32'(in_grant), 32'(gnt));
    gnt_obs = in_grant;
    m_err = m_err | zerr;
    for (int o = 0; o < NUM_PORT; o++) begin
      if (inc[o] && !claim[o]) begin
        if (m_cred[o] == SA_CREDIT_DEPTH) m_err = 1'b1;
        else m_cred[o]++;
      end else if (claim[o] && !inc[o]) begin
        m_cred[o]--;
      end
    end
    if (any) m_rr = (last + 1) % NUM_PORT;
    e.valid = claim; e.sel = sel; e.err = m_err;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check_eq("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_eq("st_valid", 32'(st_valid), 32'(e.valid));
      check_eq("st_sel", 32'(st_sel), 32'(e.sel));
      check_eq("alloc_err", 32'(alloc_err), 32'(e.err));
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0; in_req = '0; in_route_port = '0; out_credit_inc = '0;
    #1;
    check_eq("rst_st_valid", 32'(st_valid), 32'd0);
    check_eq("rst_st_sel", 32'(st_sel), 32'd0);
    check_eq("rst_alloc_err", 32'(alloc_err), 32'd0);
    check_eq("rst_in_grant", 32'(in_grant), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    sb_q.delete();
  endtask

  logic [NUM_PORT-1:0] g;
  logic [NUM_PORT-1:0] conflict_exp [4];
  logic [SEL_W-1:0]    bc_sel;
  logic [NUM_PORT-1:0] p_req;
  logic [SEL_W-1:0]    p_route;
  logic [NUM_PORT-1:0] r_inc, v;
  int                  cnt;

  initial begin
    rst = 1'b0; in_req = '0; in_route_port = '0; out_credit_inc = '0;
`ifdef QUADTREE_SA_STATS_EN
    stats_clr = 1'b0;
`endif
    model_reset();

    // Single unicast: input 0 -> output 2.
    reset_dut();
    step(5'b00001, rt(0, 5'b00100), '0, g);
    check_eq("uni_grant", 32'(g), 32'h01);
    check_eq("uni_st_valid", 32'(st_valid), 32'h04);
    check_eq("uni_st_sel2", 32'(st_sel[2*NUM_PORT +: NUM_PORT]), 32'h01);

    // Conflict on output 4 with credits replenished: grants alternate 0,1,0,1.
    reset_dut();
    conflict_exp[0] = 5'b00001; conflict_exp[1] = 5'b00010;
    conflict_exp[2] = 5'b00001; conflict_exp[3] = 5'b00010;
    for (int c = 0; c < 4; c++) begin
      step(5'b00011, rt(0, 5'b10000) | rt(1, 5'b10000), 5'b10000, g);
      check_eq("conflict_grant", 32'(g), 32'(conflict_exp[c]));
    end
    check_eq("conflict_no_err", 32'(alloc_err), 32'd0);

    // Atomic broadcast blocked by output 2 having no credit.
    reset_dut();
    repeat (4) step(5'b00100, rt(2, 5'b00100), '0, g);
    step(5'b10001, rt(4, 5'b01111) | rt(0, 5'b00001), '0, g);
    check_eq("bc_blocked", 32'(g), 32'h01);
    step(5'b10000, rt(4, 5'b01111), 5'b00100, g);
    check_eq("bc_wait_credit", 32'(g), 32'h00);
    step(5'b10000, rt(4, 5'b01111), '0, g);
    check_eq("bc_grant", 32'(g), 32'h10);
    check_eq("bc_st_valid", 32'(st_valid), 32'h0F);
    bc_sel = '0;
    for (int o = 0; o < 4; o++) bc_sel[o*NUM_PORT +: NUM_PORT] = 5'b10000;
    check_eq("bc_st_sel", 32'(st_sel), 32'(bc_sel));

    // Credit exhaustion: exactly 4 grants without returns.
    reset_dut();
    cnt = 0;
    repeat (6) begin
      step(5'b01000, rt(3, 5'b10000), '0, g);
      cnt += int'(g[3]);
    end
    check_eq("exhaust_count", 32'(cnt), 32'd4);

    // Grant with simultaneous return leaves credit unchanged.
    reset_dut();
    repeat (2) step(5'b01000, rt(3, 5'b10000), 5'b10000, g);
    cnt = 0;
    repeat (6) begin
      step(5'b01000, rt(3, 5'b10000), '0, g);
      cnt += int'(g[3]);
    end
    check_eq("inc_dec_hold_count", 32'(cnt), 32'd4);

    // Credit return at full credit: error, credit stays at 4.
    reset_dut();
    step('0, '0, 5'b00010, g);
    check_eq("sat_err", 32'(alloc_err), 32'd1);
    cnt = 0;
    repeat (5) begin
      step(5'b00010, rt(1, 5'b00010), '0, g);
      cnt += int'(g[1]);
    end
    check_eq("sat_count", 32'(cnt), 32'd4);

    // Zero route vector: drained, no traversal, error.
    reset_dut();
    step(5'b00100, '0, '0, g);
    check_eq("zero_grant", 32'(g), 32'h04);
    check_eq("zero_st_valid", 32'(st_valid), 32'd0);
    check_eq("zero_err", 32'(alloc_err), 32'd1);

    // Random traffic with holding of ungranted requests; reset mid-stream.
    reset_dut();
    p_req = '0; p_route = '0;
    for (int c = 0; c < 300; c++) begin
      if (c == 150) begin
        reset_dut();
        p_req = '0; p_route = '0;
      end
      for (int i = 0; i < NUM_PORT; i++) begin
        if (!p_req[i] && $urandom_range(0, 1) == 1) begin
          if ($urandom_range(0, 39) == 0) v = '0;
          else if ($urandom_range(0, 9) < 7) v = NUM_PORT'(1) << $urandom_range(0, NUM_PORT-1);
          else begin
            v = NUM_PORT'($urandom_range(1, 31));
          end
          p_req[i] = 1'b1;
          p_route[i*NUM_PORT +: NUM_PORT] = v;
        end
      end
      r_inc = '0;
      for (int o = 0; o < NUM_PORT; o++)
        if ($urandom_range(0, 2) == 0) r_inc[o] = 1'b1;
      step(p_req, p_route, r_inc, g);
      for (int i = 0; i < NUM_PORT; i++)
        if (g[i]) begin
          p_req[i] = 1'b0;
          p_route[i*NUM_PORT +: NUM_PORT] = '0;
        end
    end

`ifdef QUADTREE_SA_STATS_EN
    // Input 2 blocked three cycles on drained output 1, then cleared.
    reset_dut();
    repeat (4) step(5'b00010, rt(1, 5'b00010), '0, g);
    repeat (3) step(5'b00100, rt(2, 5'b00010), '0, g);
    check_eq("stall_cnt2", 32'(stall_cnt[2*STALL_W +: STALL_W]), 32'd3);
    stats_clr = 1'b1;
    step('0, '0, '0, g);
    stats_clr = 1'b0;
    check_eq("stall_clr", 32'(stall_cnt[2*STALL_W +: STALL_W]), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
